// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS fetch path.
package mips_pkg;

  localparam int          INST_W           = 32;
  localparam int          ADDR_W           = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_INC           = 32'd4;
  localparam logic [31:0] NOP              = 32'h0000_0000;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } ifq_entry_t;

  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifq_fifo.sv
// Generic synchronous FIFO with flush; storage is flops so a pushed word
// is visible at the head on the cycle after the push.
module ifq_fifo #(
  parameter  int DEPTH = 4,
  parameter  int W     = 64,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          empty;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/mips_ifetch_queue.sv
// Instruction fetch: sequential PC generation, credit-limited imem reads,
// prefetch queue to decode, redirect flush/squash. Optional IFETCH_PERF_EN adds counters.
module mips_ifetch_queue
  import mips_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic              imem_rvalid,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready,
`ifdef IFETCH_PERF_EN
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_stall,
  output logic [31:0]       perf_squashed,
`endif
  output logic [ADDR_W-1:0] pc_out
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] resp_pc;
  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     outstanding_nxt;
  logic [CW-1:0]     squash;
  logic [CW-1:0]     count;
  logic [CW:0]       credit_used;
  logic              issue;
  logic              resp;
  logic              keep;
  logic              pop;
  ifq_entry_t        head;
  ifq_entry_t        wentry;

  // Queued words plus reads in flight may never exceed the queue size.
  assign credit_used     = {1'b0, count} + {1'b0, outstanding};
  assign imem_req        = reset && !redirect_valid && (credit_used < (CW+1)'(DEPTH));
  assign imem_addr       = fetch_pc;
  assign pc_out          = fetch_pc;
  assign issue           = imem_req && imem_ready;
  assign resp            = imem_rvalid && (outstanding != '0);
  assign keep            = resp && (squash == '0);
  assign pop             = inst_valid && inst_ready && !redirect_valid;
  assign outstanding_nxt = outstanding + CW'(issue) - CW'(resp);

  assign wentry.pc   = resp_pc;
  assign wentry.inst = imem_rdata;

  ifq_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(ifq_entry_t))
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (keep),
    .pop   (pop),
    .flush (redirect_valid),
    .wdata (wentry),
    .rdata (head),
    .count (count)
  );

  assign inst_valid = (count != '0);
  assign inst       = inst_valid ? head.inst : NOP;
  assign inst_pc    = inst_valid ? head.pc   : '0;

  // resp_pc tracks the PC of the next surviving response; squashed words do not advance it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      squash      <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (redirect_valid) begin
        fetch_pc <= word_align(redirect_pc);
        resp_pc  <= word_align(redirect_pc);
        squash   <= outstanding_nxt;
      end else begin
        if (issue) fetch_pc <= fetch_pc + PC_INC;
        if (keep)  resp_pc  <= resp_pc + PC_INC;
        if (resp && (squash != '0)) squash <= squash - CW'(1);
      end
    end
  end

`ifdef IFETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_fetched  <= '0;
      perf_stall    <= '0;
      perf_squashed <= '0;
    end else begin
      if (keep && !redirect_valid)                   perf_fetched  <= perf_fetched + 32'd1;
      if (!inst_valid && !redirect_valid)            perf_stall    <= perf_stall + 32'd1;
      if (resp && ((squash != '0) || redirect_valid)) perf_squashed <= perf_squashed + 32'd1;
    end
  end
`else
  // Counters compiled out; fetch behaviour is unaffected.
`endif

  a_rvalid_credit : assert property (@(posedge clk) disable iff (!reset)
    imem_rvalid |-> (outstanding != '0));

endmodule

// File: tb/tb_mips_ifetch_queue.sv
// Bench for mips_ifetch_queue: directed vector table, corner sequences and
// randomized traffic against a queue-based model of the fetch stream.
module tb_mips_ifetch_queue;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready = 1'b0;
  logic [31:0] pc_out;
`ifdef IFETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
  logic [31:0] perf_squashed;
`endif

  always #5 clk = ~clk;

  mips_ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready),
`ifdef IFETCH_PERF_EN
    .perf_fetched   (perf_fetched),
    .perf_stall     (perf_stall),
    .perf_squashed  (perf_squashed),
`endif
    .pc_out         (pc_out)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_0F96;
  endfunction

  // Model: in-order imem with per-request epoch, and the queue decode should see.
  typedef struct {logic [31:0] addr; int due; int epoch;} pend_t;
  typedef struct {logic [31:0] pc; logic [31:0] word;} ent_t;
  pend_t       pend[$];
  ent_t        mq[$];
  logic [31:0] popped[$];
  logic [31:0] fa;
  int          epoch = 0;
  int          cyc = 0;
  int          last_due = -100;
  int          n_fetch = 0;
  int          n_squash = 0;
  int          n_stall = 0;
  bit          hold_valid = 0;
  logic [31:0] hold_addr;

  logic        s_req, s_valid;
  logic [31:0] s_addr, s_pc, s_inst;

  task automatic step(input bit rdy, input bit irdy, input bit redir,
                      input logic [31:0] rpc, input int lat);
    bit    resp, exp_req, exp_valid;
    pend_t pe;
    int    d;
    imem_ready     = rdy;
    inst_ready     = irdy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    resp           = (pend.size() > 0) && (pend[0].due <= cyc);
    imem_rvalid    = resp;
    imem_rdata     = resp ? mem_word(pend[0].addr) : $urandom;
    #1;
    s_req = imem_req; s_addr = imem_addr; s_valid = inst_valid; s_pc = inst_pc; s_inst = inst;
    exp_valid = (mq.size() > 0);
    exp_req   = !redir && ((mq.size() + pend.size()) < DEPTH);
    check("inst_valid", inst_valid, exp_valid);
    if (exp_valid) begin
      check("inst_pc", inst_pc, mq[0].pc);
      check("inst", inst, mq[0].word);
    end
    check("imem_req", imem_req, exp_req);
    if (exp_req) check("imem_addr", imem_addr, fa);
    check("pc_out", pc_out, fa);
    if (hold_valid && !redir) begin
      check("req_held", imem_req, 1'b1);
      check("addr_stable", imem_addr, hold_addr);
    end
    hold_valid = exp_req && !rdy;
    hold_addr  = fa;
    if (!exp_valid && !redir) n_stall++;
    if (exp_valid && irdy && !redir) begin
      popped.push_back(mq[0].pc);
      void'(mq.pop_front());
    end
    if (resp) begin
      pe = pend.pop_front();
      if (pe.epoch == epoch && !redir) begin
        mq.push_back('{pe.addr, mem_word(pe.addr)});
        n_fetch++;
      end else begin
        n_squash++;
      end
    end
    if (exp_req && rdy) begin
      d = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
      pend.push_back('{fa, d, epoch});
      last_due = d;
      fa = fa + 32'd4;
    end
    if (redir) begin
      mq.delete();
      epoch++;
      fa = {rpc[31:2], 2'b00};
      hold_valid = 0;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b0; imem_ready = 1'b0; imem_rvalid = 1'b0; inst_ready = 1'b0;
    redirect_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_imem_req", imem_req, 1'b0);
    check("rst_inst_valid", inst_valid, 1'b0);
    check("rst_inst", inst, 32'h0);
    check("rst_inst_pc", inst_pc, 32'h0);
    check("rst_pc_out", pc_out, RPC);
    check("rst_imem_addr", imem_addr, RPC);
    pend.delete(); mq.delete(); popped.delete();
    fa = RPC; epoch++; last_due = -100;
    n_fetch = 0; n_squash = 0; n_stall = 0; hold_valid = 0;
    reset = 1'b1;
  endtask

  typedef struct {bit irdy; bit req; logic [31:0] addr; bit valid; logic [31:0] pc;} vec_t;
  vec_t tv[23];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int base;
    bit seen;

    // L=1 streaming, then 10 cycles of decode backpressure and release.
    tv[0]  = '{1, 1, 32'h00, 0, 32'h00};
    tv[1]  = '{1, 1, 32'h04, 0, 32'h00};
    tv[2]  = '{1, 1, 32'h08, 1, 32'h00};
    tv[3]  = '{1, 1, 32'h0C, 1, 32'h04};
    tv[4]  = '{1, 1, 32'h10, 1, 32'h08};
    tv[5]  = '{1, 1, 32'h14, 1, 32'h0C};
    tv[6]  = '{1, 1, 32'h18, 1, 32'h10};
    tv[7]  = '{1, 1, 32'h1C, 1, 32'h14};
    tv[8]  = '{0, 1, 32'h20, 1, 32'h18};
    tv[9]  = '{0, 1, 32'h24, 1, 32'h18};
    for (int i = 10; i < 18; i++) tv[i] = '{0, 0, 32'h28, 1, 32'h18};
    tv[18] = '{1, 0, 32'h28, 1, 32'h18};
    tv[19] = '{1, 1, 32'h28, 1, 32'h1C};
    tv[20] = '{1, 1, 32'h2C, 1, 32'h20};
    tv[21] = '{1, 1, 32'h30, 1, 32'h24};
    tv[22] = '{1, 1, 32'h34, 1, 32'h28};

    do_reset();
    for (int i = 0; i < 23; i++) begin
      step(1, tv[i].irdy, 0, 32'h0, 1);
      check($sformatf("tv%0d_req", i), s_req, tv[i].req);
      if (tv[i].req) check($sformatf("tv%0d_addr", i), s_addr, tv[i].addr);
      check($sformatf("tv%0d_valid", i), s_valid, tv[i].valid);
      if (tv[i].valid) check($sformatf("tv%0d_pc", i), s_pc, tv[i].pc);
    end

    // L=3, two reads in flight, redirect to an unaligned target.
    do_reset();
    step(1, 0, 0, 32'h0, 3);
    step(1, 0, 0, 32'h0, 3);
    step(1, 0, 1, 32'h103, 3);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step(1, 1, 0, 32'h0, 3);
      if (s_valid) begin
        seen = 1;
        check("t3_first_pc", s_pc, 32'h100);
        check("t3_first_inst", s_inst, mem_word(32'h100));
      end
    end
    check("t3_seen", seen, 1'b1);
`ifdef IFETCH_PERF_EN
    check("perf_squashed", perf_squashed, 32'd2);
    check("perf_fetched", perf_fetched, 32'(n_fetch));
    check("perf_stall", perf_stall, 32'(n_stall));
`endif

    // Sequential fetch wraps past the top of the address space.
    step(1, 1, 1, 32'hFFFF_FFF8, 1);
    base = popped.size();
    for (int i = 0; i < 30 && popped.size() < base + 3; i++) step(1, 1, 0, 32'h0, 1);
    check("t4_count", 32'(popped.size() - base), 32'd3);
    if (popped.size() >= base + 3) begin
      check("t4_pc0", popped[base],     32'hFFFF_FFF8);
      check("t4_pc1", popped[base + 1], 32'hFFFF_FFFC);
      check("t4_pc2", popped[base + 2], 32'h0000_0000);
    end

    // Random traffic with a reset in the middle of the stream.
    for (int i = 0; i < 2000; i++) begin
      if (i == 1000) begin
        do_reset();
        for (int k = 0; k < 6; k++) step(1, 1, 0, 32'h0, 1);
        check("t5_restart_pc", (popped.size() > 0) ? popped[0] : 32'hDEAD_DEAD, RPC);
      end
      step($urandom_range(0, 1) == 1, $urandom_range(0, 9) < 7,
           $urandom_range(0, 99) < 3, $urandom, 1 + $urandom_range(0, 4));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
